data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Clocked, byte-addressed, big-endian data memory for the CPU datapath. Successor to the combinational word-only data RAM.
- Adds:
  - a req/ready/done handshake with configurable wait states;
  - byte, half and word access sizes, with zero or sign extension on loads;
  - alignment and range error reporting.
- Sits between the ALU address path and the register-file writeback mux. The control unit stalls on `done`.

Parameters:
- ADDR_WIDTH, 8: byte-address bits actually decoded. Memory depth is 2**ADDR_WIDTH bytes.
- WAIT_STATES, 1: extra cycles inserted between acceptance and commit (0..15).
- INIT_ZERO, 1: 1 means the array is zero-filled at simulation start. 0 means contents are undefined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request. Sampled only while ready=1.
- we  in  1  1 = store, 0 = load. Captured with req.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- sign_ext  in  1  loads only. 1 = sign-extend, 0 = zero-extend sub-word data.
- addr  in  32  byte address.
- wdata  in  32  store data. Sub-word stores use the low bits.
- ready  out  1  controller idle; a req is accepted this cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done. 1 = access rejected, memory unchanged.
- rdata  out  32  load result, right-aligned.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, ready=1, done=0, err=0, rdata=0, wait counter=0.
  - Memory array is not reset.
  - Reset during BUSY aborts the access: no write is committed and no done is issued.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - ready=1.
  - On an edge with req=1: latch we, size, sign_ext, addr, wdata; load counter with WAIT_STATES; go to BUSY.
  - req=0 holds IDLE.
- BUSY:
  - ready=0. req is ignored; inputs may change freely.
  - On each edge with counter≠0, decrement.
  - On the edge with counter==0 (the commit edge), do one of the following:
    - error: set err=1 and write nothing;
    - store: write the bytes;
    - load: register the result into rdata.
  - Then set done=1 and go to IDLE.
- Latency: accept edge k, commit edge k+1+WAIT_STATES. done is high for exactly the cycle after the commit edge.
- Back-to-back: in the done cycle ready=1, so a new req is accepted on the same edge that drops done. Throughput is one access per WAIT_STATES+2 cycles.
- err and done are both cleared on the edge after the done cycle.
- Error conditions, evaluated on the latched command:
  - size==11;
  - size==01 with addr[0]≠0;
  - size==10 with addr[1:0]≠0;
  - addr ≥ 2**ADDR_WIDTH (any upper bit set).
  - On error, rdata is unchanged and no byte is written.
- Byte order is big-endian, with a = addr[ADDR_WIDTH-1:0]:
  - word: {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - half: {mem[a], mem[a+1]}.
  - byte: mem[a].
- Because alignment is enforced, a+3 never wraps past the top.
- Stores:
  - byte: mem[a] = wdata[7:0].
  - half: mem[a] = wdata[15:8], mem[a+1] = wdata[7:0].
  - word: all 4 bytes, wdata[31:24] to mem[a].
  - Only the addressed bytes change.
- Loads:
  - The result is placed in rdata[7:0] (byte) or rdata[15:0] (half).
  - Upper bits are filled with the sign bit when sign_ext=1, else with 0.
  - Word loads ignore sign_ext.
- rdata holds its last load value through stores, errors and idle cycles.
- we is sampled only at acceptance. A store followed immediately by a load of the same address returns the newly stored data.

Test Plan:
- Reset mid-operation: WAIT_STATES=1; accept a word store of 0xDEADBEEF to 0x10, assert rst_n low one cycle later (before the commit edge); after release, a word load at 0x10 → done, err=0, rdata=0x00000000.
- Word round trip: WAIT_STATES=1; word store of 0x11223344 to 0x10, then word load at 0x10.
  - Required: done 2 edges after each accept, rdata=0x11223344.
  - Required: a byte load at 0x10 returns 0x00000011; a byte load at 0x13 returns 0x00000044.
- Sub-word stores:
  - byte store of 0xAB to 0x21 over a word of 0 at 0x20 → word load at 0x20 = 0x00AB0000.
  - half store of 0x8001 to 0x22 → word load at 0x20 = 0x00AB8001.
- Sign extension:
  - half load at 0x22 with sign_ext=1 → 0xFFFF8001; with sign_ext=0 → 0x00008001.
  - byte load at 0x21 with sign_ext=1 → 0xFFFFFFAB.
- Errors:
  - half at 0x03, word at 0x02, size=11, and addr=0x100 (ADDR_WIDTH=8) each give done=1, err=1.
  - Required after each: rdata unchanged, memory unchanged (verified by readback).
- Handshake:
  - WAIT_STATES=0: requests held high continuously → done every 2nd cycle, and ready=0 on the cycles in between.
  - WAIT_STATES=3: done 4 edges after accept.
  - A req pulse while ready=0 is ignored (no extra done).

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with req/ready/done handshake,
// configurable wait states, sub-word access with load extension, and error reporting.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [7:0]  INIT_BYTE = INIT_ZERO ? 8'h00 : 8'hxx;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic                  we_q, sign_ext_q;
  logic [1:0]            size_q;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            cnt;
  logic                  done_q, err_q;
  logic [31:0]           rdata_q;
  logic                  accept, commit, bad;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           load_val;

  logic [7:0] mem [DEPTH] = '{default: INIT_BYTE};

  assign accept = (state == IDLE) && req;
  assign commit = (state == BUSY) && (cnt == 4'd0);
  assign ready  = (state == IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

  // Alignment guarantees a+1..a+3 stay inside the array for legal accesses.
  assign a0 = addr_q[ADDR_WIDTH-1:0];
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  assign bad = (size_q == 2'b11)
             | ((size_q == 2'b01) & addr_q[0])
             | ((size_q == 2'b10) & (|addr_q[1:0]))
             | (|addr_q[31:ADDR_WIDTH]);

  always_comb begin
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    load_val = {b0, b1, b2, b3};
    case (size_q)
      2'b00:   load_val = {{24{sign_ext_q & b0[7]}}, b0};
      2'b01:   load_val = {{16{sign_ext_q & b0[7]}}, b0, b1};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      done_q <= commit;
      err_q  <= commit & bad;
      if (accept) begin
        we_q       <= we;
        sign_ext_q <= sign_ext;
        size_q     <= size;
        addr_q     <= addr;
        wdata_q    <= wdata;
        cnt        <= 4'(WAIT_STATES);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !we_q && !bad) rdata_q <= load_val;
    end
  end

  // Reset forces state to IDLE, so an aborted access can never reach commit here.
  always_ff @(posedge clk) begin
    if (commit && we_q && !bad) begin
      case (size_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        2'b10: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl; three instances share stimulus
// with WAIT_STATES of 0, 1 and 3 (index 0, 1, 2).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready_v [3];
  logic        done_v  [3];
  logic        err_v   [3];
  logic [31:0] rdata_v [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(0), .INIT_ZERO(1'b1)) dut_ws0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready_v[0]), .done(done_v[0]), .err(err_v[0]),
    .rdata(rdata_v[0]));

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(1), .INIT_ZERO(1'b1)) dut_ws1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready_v[1]), .done(done_v[1]), .err(err_v[1]),
    .rdata(rdata_v[1]));

  data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(3), .INIT_ZERO(1'b1)) dut_ws3 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready_v[2]), .done(done_v[2]), .err(err_v[2]),
    .rdata(rdata_v[2]));

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one access on instance sel; returns edges from accept to done (-1 on timeout)
  // plus err/rdata sampled in the done cycle. Inputs are scrambled after acceptance.
  task automatic do_access(input int sel, input logic w, input logic [1:0] sz,
                           input logic sx, input logic [31:0] ad, input logic [31:0] wd,
                           output int lat, output logic e, output logic [31:0] rd);
    int guard;
    guard = 0;
    while (ready_v[sel] !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    we = w; size = sz; sign_ext = sx; addr = ad; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; size = 2'b11; sign_ext = ~sx; addr = 32'hFFFF_FFFF; wdata = ~wd;
    lat = -1; e = 1'bx; rd = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_v[sel] === 1'b1) begin
        lat = i; e = err_v[sel]; rd = rdata_v[sel];
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    idle_cycles(2);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({ready_v[s], done_v[s], err_v[s], rdata_v[s]} !== {3'b100, 32'h0}) begin
        failures++;
        $display("FAIL reset_state inst%0d got ready=%b done=%b err=%b rdata=%h want 1 0 0 00000000",
                 s, ready_v[s], done_v[s], err_v[s], rdata_v[s]);
      end
    end
    rst_n = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_op();
    int lat; logic e; logic [31:0] rd;
    we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 32'hDEADBEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (ready_v[1] !== 1'b0) begin
      failures++; $display("FAIL midrst_busy ready got %b want 0", ready_v[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready_v[1] !== 1'b1) begin
      failures++; $display("FAIL midrst_async ready got %b want 1", ready_v[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done_v[1] !== 1'b0) begin
      failures++; $display("FAIL midrst_no_done done got %b want 0", done_v[1]);
    end
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL midrst_readback got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=00000000", lat, e, rd);
    end
  endtask

  task automatic test_word_round_trip();
    int lat; logic e; logic [31:0] rd;
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, e, rd);
    checks++;
    if (lat !== 2 || e !== 1'b0) begin
      failures++; $display("FAIL rt_store got lat=%0d err=%b want lat=2 err=0", lat, e);
    end
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'h11223344) begin
      failures++;
      $display("FAIL rt_load got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=11223344", lat, e, rd);
    end
    do_access(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, e, rd);
    checks++;
    if (rd !== 32'h00000011) begin
      failures++; $display("FAIL rt_byte10 rdata got %h want 00000011", rd);
    end
    do_access(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, e, rd);
    checks++;
    if (rd !== 32'h00000044) begin
      failures++; $display("FAIL rt_byte13 rdata got %h want 00000044", rd);
    end
  endtask

  task automatic test_sub_word();
    int lat; logic e; logic [31:0] rd;
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd);
    do_access(1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AB, lat, e, rd);
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd);
    checks++;
    if (rd !== 32'h00AB0000 || e !== 1'b0) begin
      failures++; $display("FAIL sub_byte_store rdata got %h err=%b want 00AB0000 err=0", rd, e);
    end
    do_access(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF8001, lat, e, rd);
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd);
    checks++;
    if (rd !== 32'h00AB8001) begin
      failures++; $display("FAIL sub_half_store rdata got %h want 00AB8001", rd);
    end
  endtask

  task automatic test_sign_ext();
    int lat; logic e; logic [31:0] rd;
    logic [1:0]  sz_t [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    logic        sx_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad_t [4] = '{32'h22, 32'h22, 32'h21, 32'h21};
    logic [31:0] ex_t [4] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFFAB, 32'h000000AB};
    for (int i = 0; i < 4; i++) begin
      do_access(1, 1'b0, sz_t[i], sx_t[i], ad_t[i], 32'h0, lat, e, rd);
      checks++;
      if (rd !== ex_t[i]) begin
        failures++; $display("FAIL sign_ext_%0d rdata got %h want %h", i, rd, ex_t[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat; logic e; logic [31:0] rd;
    logic        we_t [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz_t [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [31:0] ad_t [6] = '{32'h03, 32'h02, 32'h20, 32'h20, 32'h100, 32'h100};
    logic [31:0] rb_a [3] = '{32'h00, 32'h04, 32'h20};
    logic [31:0] rb_e [3] = '{32'h0, 32'h0, 32'h00AB8001};
    for (int i = 0; i < 6; i++) begin
      do_access(1, we_t[i], sz_t[i], 1'b1, ad_t[i], 32'hFFFFFFFF, lat, e, rd);
      checks++;
      if (lat !== 2 || e !== 1'b1 || rd !== 32'h000000AB) begin
        failures++;
        $display("FAIL err_case_%0d got lat=%0d err=%b rdata=%h want lat=2 err=1 rdata=000000AB", i, lat, e, rd);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_access(1, 1'b0, 2'b10, 1'b0, rb_a[i], 32'h0, lat, e, rd);
      checks++;
      if (rd !== rb_e[i] || e !== 1'b0) begin
        failures++; $display("FAIL err_readback_%0d rdata got %h err=%b want %h err=0", i, rd, e, rb_e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_cycles(8);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0; req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done_v[0] !== ((i % 2) == 0) || ready_v[0] !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL b2b_edge_%0d got done=%b ready=%b want %0d %0d",
                 i, done_v[0], ready_v[0], (i % 2) == 0, (i % 2) == 0);
      end
    end
    req = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_wait3();
    int lat; logic e; logic [31:0] rd;
    do_access(2, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, e, rd);
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      failures++; $display("FAIL wait3_latency got lat=%0d err=%b want lat=4 err=0", lat, e);
    end
  endtask

  task automatic test_ignored_req();
    int n_done;
    idle_cycles(6);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (ready_v[1] !== 1'b0) begin
      failures++; $display("FAIL ign_busy ready got %b want 0", ready_v[1]);
    end
    req = 1'b1; addr = 32'h20;
    @(posedge clk); #1;
    req = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_v[1] === 1'b1) n_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 1 || rdata_v[1] !== 32'h11223344) begin
      failures++;
      $display("FAIL ign_pulse got dones=%0d rdata=%h want dones=1 rdata=11223344", n_done, rdata_v[1]);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_word_round_trip();
    test_sub_word();
    test_sign_ext();
    test_errors();
    test_back_to_back();
    test_wait3();
    test_ignored_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
